// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data memory responder with a fixed LATENCY from accept to response.
// Define DMEM_SUBWORD_EN to enable byte/half accesses; otherwise every access is a word.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);
   localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
   logic [1:0] state;
   logic [3:0] cnt;
   logic weQ, unsignedQ, errQ;
   logic [1:0] sizeQ;
   logic [31:0] addrQ, wdataQ, rdataQ;
   logic [31:0] mem [DEPTH_WORDS];
   logic accept, enterResp, curWe, curUns, err;
   logic [1:0] curSize;
   logic [31:0] curAddr, curWdata, word, loadData, storeData;
   logic [3:0] laneEn;
   logic [AW-1:0] idx;

   assign accept = state == IDLE && req_valid;
   assign enterResp = (accept && LATENCY == 1) || (state == WAIT && cnt == 4'd0);
   // With LATENCY=1 the access happens on the accept edge itself, so it must use the live request.
   assign curWe = state == IDLE ? req_we : weQ;
   assign curUns = state == IDLE ? req_unsigned : unsignedQ;
   assign curSize = state == IDLE ? req_size : sizeQ;
   assign curAddr = state == IDLE ? req_addr : addrQ;
   assign curWdata = state == IDLE ? req_wdata : wdataQ;
   assign idx = curAddr[AW+1:2];
   assign word = mem[idx];

`ifdef DMEM_SUBWORD_EN
   logic [31:0] shifted;
   always_comb begin
      shifted = word >> {curAddr[1:0], 3'b000};
      err = curAddr >= 32'(DEPTH_WORDS * 4) || curSize == 2'b11 || (curSize == 2'b01 && curAddr[0])
         || (curSize == 2'b10 && curAddr[1:0] != 2'b00);
      laneEn = curSize == 2'b00 ? 4'b0001 << curAddr[1:0] : curSize == 2'b01 ? (curAddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      storeData = curSize == 2'b00 ? {4{curWdata[7:0]}} : curSize == 2'b01 ? {2{curWdata[15:0]}} : curWdata;
      loadData = curSize == 2'b00 ? {{24{shifted[7] & ~curUns}}, shifted[7:0]}
         : curSize == 2'b01 ? {{16{shifted[15] & ~curUns}}, shifted[15:0]} : word;
   end
`else
   logic unusedSubword;
   assign unusedSubword = ^{curSize, curUns};
   always_comb begin
      err = curAddr >= 32'(DEPTH_WORDS * 4) || curAddr[1:0] != 2'b00;
      laneEn = 4'b1111;
      storeData = curWdata;
      loadData = word;
   end
`endif

   always_ff @(posedge clk) begin
      if (accept) begin
         weQ <= req_we;
         unsignedQ <= req_unsigned;
         sizeQ <= req_size;
         addrQ <= req_addr;
         wdataQ <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= 4'd0;
         rdataQ <= 32'd0;
         errQ <= 1'b0;
      end else if (enterResp) begin
         state <= RESP;
         rdataQ <= (err || curWe) ? 32'd0 : loadData;
         errQ <= err;
      end else if (accept) begin
         state <= WAIT;
         cnt <= 4'(LATENCY - 2);
      end else if (state == WAIT) begin
         cnt <= cnt - 4'd1;
      end else if (state == RESP && rsp_ready) begin
         state <= IDLE;
         rdataQ <= 32'd0;
         errQ <= 1'b0;
      end
   end

   // Memory is never reset; a reset on the commit edge suppresses the write.
   always_ff @(posedge clk) begin
      if (!reset && enterResp && curWe && !err)
         for (int b = 0; b < 4; b++)
            if (laneEn[b]) mem[idx][8*b +: 8] <= storeData[8*b +: 8];
   end

   assign req_ready = state == IDLE;
   assign rsp_valid = state == RESP;
   assign rsp_rdata = rdataQ;
   assign rsp_err = errQ;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: three responders (LATENCY 1, 2, 3) checked every cycle against a transaction-level model,
// plus directed transactions with literal expectations.
module tb_dmem_responder;
   logic clk = 1'b0, reset = 1'b1;
   logic reqValid [3], reqWe [3], reqUns [3], rspReady [3];
   logic [1:0] reqSize [3];
   logic [31:0] reqAddr [3], reqWdata [3];
   wire reqReady [3], rspValid [3], rspErr [3];
   wire [31:0] rspRdata [3];
   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : gDut
      dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(g + 1)) dut (
         .clk(clk), .reset(reset), .req_valid(reqValid[g]), .req_ready(reqReady[g]), .req_we(reqWe[g]),
         .req_addr(reqAddr[g]), .req_wdata(reqWdata[g]), .req_size(reqSize[g]), .req_unsigned(reqUns[g]),
         .rsp_valid(rspValid[g]), .rsp_ready(rspReady[g]), .rsp_rdata(rspRdata[g]), .rsp_err(rspErr[g]));
   end

   task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s[lat%0d] t=%0t: got %h want %h", name, i + 1, $time, act, exp);
      end
   endtask

   // Transaction-level model: a request is pending from accept until the response handshake;
   // its access happens LATENCY-1 edges after the accept edge, and it is visible once that access is done.
   bit started, pend [3], cWe [3], cUns [3], expErr [3], expKnown [3];
   int age [3];
   logic [1:0] cSize [3];
   logic [31:0] cAddr [3], cWdata [3], expData [3];
   logic [31:0] mMem [3][1024];
   bit mKnown [3][1024];

   task automatic commit(input int i);
      logic [31:0] a, w;
      int idx;
      bit e;
      a = cAddr[i];
      idx = int'(a[11:2]);
`ifdef DMEM_SUBWORD_EN
      e = a >= 32'd4096 || cSize[i] == 2'd3 || (cSize[i] == 2'd1 && a[0]) || (cSize[i] == 2'd2 && a[1:0] != 2'd0);
`else
      e = a >= 32'd4096 || a[1:0] != 2'd0;
`endif
      expErr[i] = e;
      expData[i] = 32'd0;
      expKnown[i] = 1'b1;
      if (e) return;
      if (cWe[i]) begin
         w = mMem[i][idx];
`ifdef DMEM_SUBWORD_EN
         if (cSize[i] == 2'd0) w[8*a[1:0] +: 8] = cWdata[i][7:0];
         else if (cSize[i] == 2'd1) w[16*a[1] +: 16] = cWdata[i][15:0];
         else begin
            w = cWdata[i];
            mKnown[i][idx] = 1'b1;
         end
`else
         w = cWdata[i];
         mKnown[i][idx] = 1'b1;
`endif
         mMem[i][idx] = w;
      end else begin
         expKnown[i] = mKnown[i][idx];
         w = mMem[i][idx] >> (8 * a[1:0]);
`ifdef DMEM_SUBWORD_EN
         if (cSize[i] == 2'd0) expData[i] = cUns[i] ? {24'd0, w[7:0]} : {{24{w[7]}}, w[7:0]};
         else if (cSize[i] == 2'd1) expData[i] = cUns[i] ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
         else expData[i] = mMem[i][idx];
`else
         expData[i] = mMem[i][idx];
`endif
      end
   endtask

   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         if (started) begin
            bit v;
            v = pend[i] && age[i] >= i;
            chk("req_ready", i, 32'(reqReady[i]), 32'(!pend[i]));
            chk("rsp_valid", i, 32'(rspValid[i]), 32'(v));
            chk("rsp_err", i, 32'(rspErr[i]), 32'(v && expErr[i]));
            if (!v || expKnown[i]) chk("rsp_rdata", i, rspRdata[i], v ? expData[i] : 32'd0);
         end
         if (reset) pend[i] = 1'b0;
         else if (!pend[i]) begin
            if (reqValid[i]) begin
               cWe[i] = reqWe[i];
               cUns[i] = reqUns[i];
               cSize[i] = reqSize[i];
               cAddr[i] = reqAddr[i];
               cWdata[i] = reqWdata[i];
               pend[i] = 1'b1;
               age[i] = 0;
               if (i == 0) commit(i);
            end
         end else if (age[i] >= i) begin
            if (rspReady[i]) pend[i] = 1'b0;
         end else begin
            age[i]++;
            if (age[i] == i) commit(i);
         end
      end
      if (reset) started = 1'b1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic txn(input int i, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input bit uns, output logic [31:0] data, output bit err, output int lat);
      int n;
      reqValid[i] = 1'b1;
      reqWe[i] = we;
      reqAddr[i] = addr;
      reqWdata[i] = wdata;
      reqSize[i] = size;
      reqUns[i] = uns;
      n = 0;
      while (!reqReady[i] && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) chk("accept_timeout", i, 32'(n), 32'd0);
      step();
      reqValid[i] = 1'b0;
      lat = 1;
      while (!rspValid[i] && lat < 40) begin
         step();
         lat++;
      end
      if (lat >= 40) chk("rsp_timeout", i, 32'(lat), 32'(i + 1));
      data = rspRdata[i];
      err = rspErr[i];
      if (rspReady[i]) step();
   endtask

   logic [31:0] d;
   bit e;
   int lat, acc, val;

   initial begin
      for (int i = 0; i < 3; i++) begin
         reqValid[i] = 1'b0;
         reqWe[i] = 1'b0;
         reqUns[i] = 1'b0;
         reqSize[i] = 2'd2;
         reqAddr[i] = 32'd0;
         reqWdata[i] = 32'd0;
         rspReady[i] = 1'b1;
      end
      step();
      step();
      reset = 1'b0;
      chk("reset_ready", 1, 32'(reqReady[1]), 32'd1);
      chk("reset_valid", 1, 32'(rspValid[1]), 32'd0);
      chk("reset_rdata", 1, rspRdata[1], 32'd0);
      chk("reset_err", 1, 32'(rspErr[1]), 32'd0);
      // store then load, LATENCY=2
      txn(1, 1, 32'h10, 32'hDEADBEEF, 2'd2, 0, d, e, lat);
      chk("st_lat", 1, 32'(lat), 32'd2);
      chk("st_rdata", 1, d, 32'd0);
      chk("st_err", 1, 32'(e), 32'd0);
      txn(1, 0, 32'h10, 32'd0, 2'd2, 0, d, e, lat);
      chk("ld_lat", 1, 32'(lat), 32'd2);
      chk("ld_data", 1, d, 32'hDEADBEEF);
      chk("ld_err", 1, 32'(e), 32'd0);
      // error requests leave memory untouched
      txn(1, 1, 32'h4, 32'hCAFEF00D, 2'd2, 0, d, e, lat);
      txn(1, 0, 32'h1000, 32'd0, 2'd2, 0, d, e, lat);
      chk("oor_err", 1, 32'(e), 32'd1);
      chk("oor_rdata", 1, d, 32'd0);
      txn(1, 0, 32'h6, 32'd0, 2'd2, 0, d, e, lat);
      chk("misal_err", 1, 32'(e), 32'd1);
      chk("misal_rdata", 1, d, 32'd0);
      txn(1, 1, 32'h6, 32'h12345678, 2'd2, 0, d, e, lat);
      chk("misal_st_err", 1, 32'(e), 32'd1);
      txn(1, 0, 32'h4, 32'd0, 2'd2, 0, d, e, lat);
      chk("after_err", 1, d, 32'hCAFEF00D);
      txn(1, 1, 32'hFFC, 32'hA5A5A5A5, 2'd2, 0, d, e, lat);
      txn(1, 0, 32'hFFC, 32'd0, 2'd2, 0, d, e, lat);
      chk("last_word", 1, d, 32'hA5A5A5A5);
      chk("last_err", 1, 32'(e), 32'd0);
`ifdef DMEM_SUBWORD_EN
      txn(1, 1, 32'h20, 32'h000000F0, 2'd2, 0, d, e, lat);
      txn(1, 0, 32'h20, 32'd0, 2'd0, 0, d, e, lat);
      chk("lb_signed", 1, d, 32'hFFFFFFF0);
      txn(1, 0, 32'h20, 32'd0, 2'd0, 1, d, e, lat);
      chk("lb_unsigned", 1, d, 32'h000000F0);
      txn(1, 1, 32'h22, 32'h00001234, 2'd1, 0, d, e, lat);
      txn(1, 0, 32'h20, 32'd0, 2'd2, 0, d, e, lat);
      chk("sh_merge", 1, d, 32'h123400F0);
      txn(1, 0, 32'h21, 32'd0, 2'd1, 0, d, e, lat);
      chk("lh_misal", 1, 32'(e), 32'd1);
      txn(1, 0, 32'h20, 32'd0, 2'd3, 0, d, e, lat);
      chk("size_rsvd", 1, 32'(e), 32'd1);
`else
      txn(1, 1, 32'h20, 32'h000000F0, 2'd2, 0, d, e, lat);
      txn(1, 0, 32'h20, 32'd0, 2'd0, 0, d, e, lat);
      chk("size_ignored", 1, d, 32'h000000F0);
      txn(1, 0, 32'h21, 32'd0, 2'd0, 1, d, e, lat);
      chk("byte_misal", 1, 32'(e), 32'd1);
`endif
      // response held while rsp_ready is low
      rspReady[1] = 1'b0;
      txn(1, 0, 32'h10, 32'd0, 2'd2, 0, d, e, lat);
      for (int k = 0; k < 5; k++) begin
         chk("hold_valid", 1, 32'(rspValid[1]), 32'd1);
         chk("hold_rdata", 1, rspRdata[1], 32'hDEADBEEF);
         chk("hold_ready", 1, 32'(reqReady[1]), 32'd0);
         step();
      end
      rspReady[1] = 1'b1;
      step();
      chk("release_ready", 1, 32'(reqReady[1]), 32'd1);
      chk("release_valid", 1, 32'(rspValid[1]), 32'd0);
      // reset while a response is presented drops it
      rspReady[1] = 1'b0;
      txn(1, 0, 32'h10, 32'd0, 2'd2, 0, d, e, lat);
      reset = 1'b1;
      step();
      reset = 1'b0;
      rspReady[1] = 1'b1;
      chk("rst_resp_valid", 1, 32'(rspValid[1]), 32'd0);
      chk("rst_resp_rdata", 1, rspRdata[1], 32'd0);
      // reset one cycle after a store accept, LATENCY=3
      txn(2, 1, 32'h8, 32'h00000011, 2'd2, 0, d, e, lat);
      chk("lat3", 2, 32'(lat), 32'd3);
      reqValid[2] = 1'b1;
      reqWe[2] = 1'b1;
      reqAddr[2] = 32'h8;
      reqWdata[2] = 32'h00000055;
      step();
      reqValid[2] = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort_valid", 2, 32'(rspValid[2]), 32'd0);
      chk("abort_rdata", 2, rspRdata[2], 32'd0);
      chk("abort_err", 2, 32'(rspErr[2]), 32'd0);
      chk("abort_ready", 2, 32'(reqReady[2]), 32'd1);
      txn(2, 0, 32'h8, 32'd0, 2'd2, 0, d, e, lat);
      chk("abort_old", 2, d, 32'h00000011);
      // LATENCY=1 back-to-back
      txn(0, 1, 32'h0, 32'h0BADCAFE, 2'd2, 0, d, e, lat);
      chk("lat1", 0, 32'(lat), 32'd1);
      reqValid[0] = 1'b1;
      reqWe[0] = 1'b0;
      reqAddr[0] = 32'h0;
      acc = 0;
      val = 0;
      for (int k = 0; k < 12; k++) begin
         acc += int'(reqReady[0]);
         val += int'(rspValid[0]);
         if (rspValid[0]) chk("b2b_data", 0, rspRdata[0], 32'h0BADCAFE);
         step();
      end
      reqValid[0] = 1'b0;
      chk("b2b_accepts", 0, 32'(acc), 32'd6);
      chk("b2b_valids", 0, 32'(val), 32'd6);
      step();
      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
